score_keeper_multi: RTL

SCORE_KEEPER_MULTI -- requirements
Module: score_keeper_multi

---
 rtl/pong_pkg.sv | 16 +
 rtl/score_keeper_multi_if.sv | 33 +++
 rtl/score_counter.sv | 37 +++
 rtl/score_keeper_multi.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and default configuration for the score keeper.
package pong_pkg;

  // Game-flow states of the score keeper.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RALLY   = 2'd1,
    PENDING = 2'd2,
    OVER    = 2'd3
  } game_state_e;

  localparam int DEF_NUM_PLAYERS = 2;
  localparam int DEF_SCORE_W     = 8;
  localparam int DEF_WIN_SCORE   = 11;

endpackage : pong_pkg

// File: rtl/score_keeper_multi_if.sv
// Game-event inputs and scoreboard outputs of the score keeper, bundled.
interface score_keeper_multi_if
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int SCORE_W     = DEF_SCORE_W
);
  localparam int IDX_W = $clog2(NUM_PLAYERS);

  logic                           game_start;
  logic [NUM_PLAYERS-1:0]         hit;
  logic                           point_lost;
  logic [9:0]                     x_pixel;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic [IDX_W-1:0]               last_hitter;
  logic                           hitter_valid;
  logic                           point_strobe;
  logic                           game_over;
  logic [IDX_W-1:0]               winner;

  // Game logic / video side: produces events, consumes the scoreboard.
  modport master (
    output game_start, hit, point_lost, x_pixel,
    input  scores, last_hitter, hitter_valid, point_strobe, game_over, winner
  );

  // Score keeper side.
  modport slave (
    input  game_start, hit, point_lost, x_pixel,
    output scores, last_hitter, hitter_valid, point_strobe, game_over, winner
  );

endinterface : score_keeper_multi_if

// File: rtl/score_counter.sv
// Saturating up-counter for one player's score, with synchronous clear.
module score_counter #(
  parameter int SCORE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] count
);

  logic [SCORE_W-1:0] count_d, count_q;

  // Next count: clear wins, otherwise add one unless already at full scale.
  always_comb begin
    // NOTE: assigning a default first means every path writes count_d, so no latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + SCORE_W'(1);
    end
  end

  // Score register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : score_counter

// File: rtl/score_keeper_multi.sv
// Multi-player pong score keeper: tracks the rally's last hitter, credits
// the point at the next line start after the ball is lost, and ends the
// game when a player reaches WIN_SCORE.
module score_keeper_multi
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = DEF_NUM_PLAYERS,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic                 clk_25MHz,
  input  logic                 reset_n,
  score_keeper_multi_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_PLAYERS);

  // Reject configurations the scoring rules cannot honour.
  if ((WIN_SCORE < 1) || (WIN_SCORE > (2 ** SCORE_W) - 1)) begin : g_bad_win_score
    $error("score_keeper_multi: WIN_SCORE out of range for SCORE_W");
  end
  if ((NUM_PLAYERS < 2) || (NUM_PLAYERS > 4)) begin : g_bad_num_players
    $error("score_keeper_multi: NUM_PLAYERS must be 2..4");
  end

  game_state_e        state_d, state_q;
  logic [IDX_W-1:0]   last_hitter_d, last_hitter_q;
  logic               hitter_valid_d, hitter_valid_q;
  logic               point_strobe_d, point_strobe_q;
  logic               game_over_d, game_over_q;
  logic [IDX_W-1:0]   winner_d, winner_q;

  logic               any_hit;
  logic [IDX_W-1:0]   low_idx;
  logic               inc_en;
  logic               clr;
  logic [SCORE_W-1:0] score_arr [NUM_PLAYERS];
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] next_score;

  // Lowest-numbered paddle reporting a hit this cycle.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (bus.hit[i]) low_idx = IDX_W'(i);
    end
  end

  assign any_hit    = |bus.hit;
  assign cur_score  = score_arr[last_hitter_q];
  assign next_score = (cur_score == '1) ? cur_score : cur_score + SCORE_W'(1);

  // Next-state and output decisions; game_start overrides everything.
  always_comb begin
    state_d        = state_q;
    last_hitter_d  = last_hitter_q;
    hitter_valid_d = hitter_valid_q;
    point_strobe_d = 1'b0;
    game_over_d    = game_over_q;
    winner_d       = winner_q;
    inc_en         = 1'b0;
    clr            = 1'b0;

    if (bus.game_start) begin
      state_d        = IDLE;
      last_hitter_d  = '0;
      hitter_valid_d = 1'b0;
      game_over_d    = 1'b0;
      winner_d       = '0;
      clr            = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A lost ball with nobody credited is not a point.
          if (any_hit) begin
            state_d        = RALLY;
            last_hitter_d  = low_idx;
            hitter_valid_d = 1'b1;
          end
        end
        RALLY: begin
          // Losing the ball outranks a simultaneous hit.
          if (bus.point_lost) begin
            state_d = PENDING;
          end else if (any_hit) begin
            last_hitter_d = low_idx;
          end
        end
        PENDING: begin
          // Commit at line start so the scoreboard changes between lines.
          if (bus.x_pixel == 10'd0) begin
            inc_en         = 1'b1;
            point_strobe_d = 1'b1;
            if (next_score >= SCORE_W'(WIN_SCORE)) begin
              state_d     = OVER;
              game_over_d = 1'b1;
              winner_d    = last_hitter_q;
            end else begin
              state_d        = IDLE;
              hitter_valid_d = 1'b0;
            end
          end
        end
        OVER: begin
          state_d = OVER;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    // NOTE: only control/score flops exist here; all are cleared by the async reset.
    if (!reset_n) begin
      state_q        <= IDLE;
      last_hitter_q  <= '0;
      hitter_valid_q <= 1'b0;
      point_strobe_q <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= '0;
    end else begin
      state_q        <= state_d;
      last_hitter_q  <= last_hitter_d;
      hitter_valid_q <= hitter_valid_d;
      point_strobe_q <= point_strobe_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  // One saturating counter per player.
  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    score_counter #(
      .SCORE_W (SCORE_W)
    ) u_score (
      .clk   (clk_25MHz),
      .rst_n (reset_n),
      .clr   (clr),
      .inc   (inc_en && (last_hitter_q == IDX_W'(g))),
      .count (score_arr[g])
    );
    assign bus.scores[g*SCORE_W +: SCORE_W] = score_arr[g];
  end

  assign bus.last_hitter  = last_hitter_q;
  assign bus.hitter_valid = hitter_valid_q;
  assign bus.point_strobe = point_strobe_q;
  assign bus.game_over    = game_over_q;
  assign bus.winner       = winner_q;

endmodule : score_keeper_multi
